// File: rtl/fifo_ctrl8.sv
// Pointer/flag controller for an 8-entry register-file FIFO: row write enables, head select, count and flags.
// Latency: wr_row_en is combinational; count, flags and rd_sel update at the edge ending an accepted request.
// Backpressure: writes are rejected when full unless paired with a read; reads are rejected when empty (sticky error flags).
module fifo_ctrl8 #(
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [7:0] wr_row_en,
    output logic [2:0] rd_sel,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       almost_full,
    output logic       almost_empty,
    output logic       overflow,
    output logic       underflow
);

    localparam logic [3:0] AF_TH = 4'(AFULL_TH);
    localparam logic [3:0] AE_TH = 4'(AEMPTY_TH);

    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       wr_acc;
    logic       rd_acc;
    logic [3:0] count_nxt;

    // A write into a full FIFO is legal only when the head is popped the same cycle.
    assign wr_acc    = wr_req & (~full | rd_req);
    assign rd_acc    = rd_req & ~empty;
    assign count_nxt = count + {3'b000, wr_acc} - {3'b000, rd_acc};

    always_comb begin
        wr_row_en = 8'h00;
        if (wr_acc && !flush && !rst) begin
            wr_row_en = 8'h01 << wr_ptr;
        end
    end

    assign rd_sel = rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= 3'd0;
            rd_ptr       <= 3'd0;
            count        <= 4'd0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (4'd0 >= AF_TH);
            almost_empty <= (4'd0 <= AE_TH);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + {2'b00, wr_acc};
            rd_ptr       <= rd_ptr + {2'b00, rd_acc};
            count        <= count_nxt;
            full         <= (count_nxt == 4'd8);
            empty        <= (count_nxt == 4'd0);
            almost_full  <= (count_nxt >= AF_TH);
            almost_empty <= (count_nxt <= AE_TH);
            if (wr_req && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl8.sv
// Directed bench for fifo_ctrl8: fill, overflow, full read/write, flush/reset, empty read/write and pointer wrap.
module tb_fifo_ctrl8;

    logic       clk = 1'b0;
    logic       rst, flush, wr_req, rd_req;
    logic [7:0] wr_row_en;
    logic [2:0] rd_sel;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_ctrl8 #(.AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .rd_req(rd_req),
        .wr_row_en(wr_row_en), .rd_sel(rd_sel), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_req = 1'b1; rd_req = 1'b0;
        tick();
        #1;
        n_cmp++; if (wr_row_en !== 8'h00) begin n_err++; $display("FAIL rst_wr_row_en got %h want 00", wr_row_en); end
        tick();
        rst = 1'b0; wr_req = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if ({empty, full, almost_full, almost_empty} !== 4'b1001) begin n_err++; $display("FAIL rst_flags got %b want 1001", {empty, full, almost_full, almost_empty}); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL rst_err got %b want 00", {overflow, underflow}); end
        n_cmp++; if (rd_sel !== 3'd0) begin n_err++; $display("FAIL rst_rd_sel got %0d want 0", rd_sel); end
        n_cmp++; if (wr_row_en !== 8'h00) begin n_err++; $display("FAIL rst_idle_en got %h want 00", wr_row_en); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_en;
        for (int i = 0; i < 8; i++) begin
            exp_en = 8'h01 << i;
            wr_req = 1'b1;
            #1;
            n_cmp++; if (wr_row_en !== exp_en) begin n_err++; $display("FAIL fill_en[%0d] got %h want %h", i, wr_row_en, exp_en); end
            tick();
            n_cmp++; if (count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            n_cmp++; if (almost_full !== (i + 1 >= 6)) begin n_err++; $display("FAIL fill_afull[%0d] got %b", i, almost_full); end
            n_cmp++; if (almost_empty !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_aempty[%0d] got %b", i, almost_empty); end
            n_cmp++; if (full !== (i == 7)) begin n_err++; $display("FAIL fill_full[%0d] got %b", i, full); end
            n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
        end
        wr_req = 1'b0;
    endtask

    task automatic test_overflow();
        wr_req = 1'b1;
        #1;
        n_cmp++; if (wr_row_en !== 8'h00) begin n_err++; $display("FAIL ovf_en got %h want 00", wr_row_en); end
        tick();
        wr_req = 1'b0;
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
        n_cmp++; if ({overflow, underflow} !== 2'b10) begin n_err++; $display("FAIL ovf_flags got %b want 10", {overflow, underflow}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky[%0d] got %b want 1", i, overflow); end
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_en;
        for (int i = 0; i < 2; i++) begin
            exp_en = 8'h01 << i;
            wr_req = 1'b1; rd_req = 1'b1;
            #1;
            n_cmp++; if (wr_row_en !== exp_en) begin n_err++; $display("FAIL frw_en[%0d] got %h want %h", i, wr_row_en, exp_en); end
            tick();
            n_cmp++; if ({count, full} !== {4'd8, 1'b1}) begin n_err++; $display("FAIL frw_count[%0d] got %0d/%b want 8/1", i, count, full); end
            n_cmp++; if (rd_sel !== 3'(i + 1)) begin n_err++; $display("FAIL frw_rd_sel[%0d] got %0d want %0d", i, rd_sel, i + 1); end
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_flush_rst();
        rd_req = 1'b1;
        tick(); tick(); tick();
        rd_req = 1'b0;
        n_cmp++; if ({count, overflow} !== {4'd5, 1'b1}) begin n_err++; $display("FAIL pre_flush got %0d/%b want 5/1", count, overflow); end
        flush = 1'b1; wr_req = 1'b1;
        #1;
        n_cmp++; if (wr_row_en !== 8'h00) begin n_err++; $display("FAIL flush_en got %h want 00", wr_row_en); end
        tick();
        flush = 1'b0; wr_req = 1'b0;
        n_cmp++; if ({count, empty, overflow, rd_sel} !== {4'd0, 1'b1, 1'b0, 3'd0}) begin n_err++; $display("FAIL flush_state got cnt=%0d e=%b o=%b sel=%0d", count, empty, overflow, rd_sel); end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_cmp++; if ({underflow, count} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL pre_rst_unf got %b/%0d want 1/0", underflow, count); end
        wr_req = 1'b1; tick(); tick();
        rd_req = 1'b1; tick();
        n_cmp++; if ({count, rd_sel} !== {4'd2, 3'd1}) begin n_err++; $display("FAIL pre_rst got %0d/%0d want 2/1", count, rd_sel); end
        rst = 1'b1;
        #1;
        n_cmp++; if (wr_row_en !== 8'h00) begin n_err++; $display("FAIL rst_mid_en got %h want 00", wr_row_en); end
        tick();
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        n_cmp++; if ({count, empty, overflow, underflow, rd_sel} !== {4'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin n_err++; $display("FAIL rst_mid_state got cnt=%0d e=%b o=%b u=%b sel=%0d", count, empty, overflow, underflow, rd_sel); end
    endtask

    task automatic test_empty_rw();
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        n_cmp++; if (wr_row_en !== 8'h01) begin n_err++; $display("FAIL erw_en got %h want 01", wr_row_en); end
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        n_cmp++; if ({count, empty} !== {4'd1, 1'b0}) begin n_err++; $display("FAIL erw_count got %0d/%b want 1/0", count, empty); end
        n_cmp++; if ({underflow, overflow} !== 2'b10) begin n_err++; $display("FAIL erw_err got %b want 10", {underflow, overflow}); end
        n_cmp++; if (rd_sel !== 3'd0) begin n_err++; $display("FAIL erw_rd_sel got %0d want 0", rd_sel); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_en;
        logic [2:0] exp_sel;
        rst = 1'b1; tick(); rst = 1'b0;
        wr_req = 1'b1; tick(); tick(); tick();
        rd_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_en  = 8'h01 << ((k + 3) % 8);
            exp_sel = 3'(k % 8);
            #1;
            n_cmp++; if (wr_row_en !== exp_en) begin n_err++; $display("FAIL wrap_en[%0d] got %h want %h", k, wr_row_en, exp_en); end
            n_cmp++; if (rd_sel !== exp_sel) begin n_err++; $display("FAIL wrap_sel[%0d] got %0d want %0d", k, rd_sel, exp_sel); end
            tick();
            n_cmp++; if ({count, overflow, underflow} !== {4'd3, 2'b00}) begin n_err++; $display("FAIL wrap_state[%0d] got %0d/%b%b want 3/00", k, count, overflow, underflow); end
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_flush_rst();
        test_empty_rw();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl8.md
# fifo_ctrl8

Pointer/flag controller for the 8-entry × 8-bit register-file FIFO. It turns write requests into one-hot row write enables in the same style as the 3-to-8 decoder path. It supplies the read row select and keeps the occupancy count, full/empty/almost flags and sticky error flags. It sits between the requesting logic and the storage array; the array and data mux stay outside this block.

## Interface
Parameters:
- AFULL_TH, 6: almost_full asserts when count >= AFULL_TH (legal 1..7).
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH (legal 0..7).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of pointers, count and error flags.
- wr_req  in  1  push request; data is presented to the array the same cycle.
- rd_req  in  1  pop request; head data is valid at rd_sel while !empty.
- wr_row_en  out  8  one-hot row write enable, combinational.
- rd_sel  out  3  row index of the FIFO head; equals rd_ptr and is registered.
- count  out  4  occupancy, 0..8, registered.
- full  out  1  count == 8.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- State: wr_ptr[2:0], rd_ptr[2:0], count[3:0], overflow, underflow. All flags are registered and derived from the next-state count.
- Acceptance:
  - wr_acc = wr_req & (!full | rd_req).
  - rd_acc = rd_req & !empty.
- Write while full is accepted only together with a read. The head row is read combinationally this cycle, and the overwrite lands at the edge.
- Read while empty is always rejected, even with a simultaneous write. There is no fall-through.
- wr_row_en = decode(wr_ptr) gated by wr_acc & !flush & !rst. Exactly one bit or none is high.
- Pointer update: wr_ptr += wr_acc; rd_ptr += rd_acc. Arithmetic is modulo 8, with natural 3-bit wrap from 7 to 0.
- Count update: count + wr_acc − rd_acc. Simultaneous accepted read and write leaves count unchanged, at any level including 8.
- Error flags:
  - overflow sets on wr_req & !wr_acc.
  - underflow sets on rd_req & !rd_acc.
  - Both hold until rst or flush.
- Priority: rst > flush > normal operation.
  - rst and flush have identical effect on state.
  - Requests in a rst or flush cycle are discarded and do not set error flags.
- Reset mid-operation:
  - All stored entries are logically lost.
  - Array contents are not cleared and are not required to be.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_full = 0, almost_empty = 1, overflow = 0, underflow = 0, rd_sel = 0, wr_row_en = 0.
- Write latency: the row is written at the edge ending the wr_acc cycle. count, empty and almost flags reflect it from the next cycle.
- Read: head data is valid at rd_sel while empty = 0. The pop takes effect at the edge, and rd_sel advances the next cycle.
- First-word latency: a write in cycle N makes empty = 0 in cycle N+1, and the data is readable in N+1.
- Flags have no combinational path from wr_req or rd_req. Only wr_row_en is combinational from wr_req.
- Throughput is one push and one pop per cycle, sustained.

## Test plan
- Reset, then 8 writes with no reads:
  - wr_row_en sequences 0x01, 0x02 … 0x80.
  - count goes 1..8.
  - almost_full rises on the edge where count becomes 6.
  - full = 1 after the 8th write; empty stays 0 after the 1st.
- From full, assert a write only:
  - wr_row_en = 0 and count stays 8.
  - overflow = 1 next cycle and stays 1 through 3 further idle cycles.
- From empty, assert rd_req together with wr_req:
  - Read rejected; underflow = 1.
  - count = 1; rd_sel stays 0.
  - wr_row_en = 0x01 in that cycle.
- Pointer wrap: push/pop at steady count 3 for 20 cycles with simultaneous wr_req and rd_req.
  - count stays 3 and no error flag sets.
  - rd_sel wraps 7→0, and wr_row_en wraps 0x80→0x01.
- Full with simultaneous read and write:
  - Both are accepted, count stays 8, full stays 1.
  - rd_sel and wr_ptr both advance by 1.
- flush with count = 5, wr_req = 1 and overflow = 1, then rst mid-stream:
  - Next cycle: count = 0, empty = 1, overflow = 0, rd_sel = 0.
  - wr_row_en = 0 during the flush cycle.
  - The same result holds for rst.
